reaction_timer: RTL and testbench
=================================

# reaction_timer

Downstream consumer of the combined keyboard/mouse input stage. It runs one reaction-time trial per start request:
- waits a pseudo-random delay;
- raises a visual stimulus;
- measures in milliseconds how long the player takes to respond (space bar or left click).

Results, false-start and timeout flags, and a best-so-far score go to the display/VGA logic.

## Interface
- TICKS_PER_MS, 50000, CLOCK_50 cycles per millisecond
- MIN_DELAY_MS, 1000, minimum pre-stimulus delay in ms
- DELAY_MASK, 11'h7FF, AND-mask applied to LFSR bits [10:0] for the random part of the delay
- MAX_MS, 9999, response timeout and saturation value (must fit 14 bits)

- CLOCK_50  in  1  system clock; the block's only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level, trial request (wired to one_pressed)
- space_pressed  in  1  level, response source 1
- leftClick_pressed  in  1  level, response source 2
- stimulus  out  1  high while the player must react
- busy  out  1  high in WAIT or GO
- result_ms  out  14  last measured reaction time in ms
- result_valid  out  1  one-cycle pulse when result_ms updates with a valid reaction
- too_early  out  1  sticky: last trial was a false start
- timeout  out  1  sticky: last trial hit MAX_MS
- best_ms  out  14  lowest valid result since reset

## Operation
- Edge detection: inputs are registered once. start_rise = start & ~start_d. resp_rise = (space_pressed | leftClick_pressed) & ~resp_d. Only rises act.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, reset seed 16'hACE1, advances every cycle in all states.
- Tick counter counts 0..TICKS_PER_MS-1 and wraps. On wrap, ms_cnt increments. Both clear on every state entry.
- States:
  - IDLE, DONE, EARLY, TIMEOUT: on start_rise, go to WAIT.
    - Latch delay_ms = MIN_DELAY_MS + (lfsr[10:0] & DELAY_MASK) on that same cycle.
    - Clear too_early and timeout. result_ms holds its value.
  - WAIT: stimulus=0.
    - On resp_rise, go to EARLY and set too_early=1.
    - Otherwise, go to GO once ms_cnt reaches delay_ms.
  - GO: stimulus=1.
    - On resp_rise, go to DONE. Set result_ms = ms_cnt and pulse result_valid. If ms_cnt < best_ms, set best_ms = ms_cnt.
    - Otherwise, when ms_cnt reaches MAX_MS, go to TIMEOUT. Set result_ms = MAX_MS and timeout=1. result_valid stays low.
- start_rise during WAIT or GO is ignored.
- Simultaneous events:
  - In WAIT, resp_rise and delay expiry on the same cycle gives EARLY.
  - In GO, resp_rise and MAX_MS on the same cycle gives DONE with result_ms = MAX_MS.
  - In DONE/EARLY/TIMEOUT, start_rise and resp_rise together gives WAIT; the response is discarded.
- Arithmetic: ms_cnt is 14 bits and saturates at MAX_MS. delay_ms is 14 bits; the parameters guarantee no overflow.

## Timing
- All outputs are registered.
- Reset values: state IDLE, stimulus 0, busy 0, result_ms 0, result_valid 0, too_early 0, timeout 0, best_ms MAX_MS, LFSR 16'hACE1, all counters 0.
- Reset mid-trial aborts the trial on the next clock edge; there is no result pulse.
- Input to edge: a raw input high at cycle N produces its rise at cycle N+1, because of the input register.
- WAIT entered at cycle W: stimulus rises at cycle W + delay_ms*TICKS_PER_MS.
- GO entered at cycle G, response rise detected at cycle R:
  - result_ms = floor((R-G)/TICKS_PER_MS).
  - result_valid is high for exactly cycle R+1.
  - stimulus falls at R+1.
- busy tracks the state register. It has no added latency.

## Test plan
- Params TICKS_PER_MS=4, MIN_DELAY_MS=3, DELAY_MASK=0. Pulse start, wait, then raise space 10 cycles after stimulus rises. Required: stimulus rises 12 cycles after WAIT entry; result_ms=2; result_valid is a 1-cycle pulse; best_ms=2.
- Same params. Raise leftClick 5 cycles after WAIT entry. Required: too_early=1, stimulus never rises, result_ms unchanged, result_valid stays 0.
- Params TICKS_PER_MS=4, MAX_MS=20. Apply no response. Required: TIMEOUT 80 cycles after GO entry, result_ms=20, timeout=1, result_valid=0, best_ms unchanged.
- Run two trials with reactions of 7 ms then 4 ms, then one of 9 ms. Required: best_ms = 7, then 4, then stays 4.
- Assert reset mid-GO. Required: next cycle state IDLE, stimulus=0, busy=0, best_ms=MAX_MS. Hold space high continuously, then pulse start: no early fault until space is released and re-pressed.
- Raise start during WAIT and GO: no change. Assert response and delay expiry on the same cycle: EARLY.

Source files
------------

// File: rtl/reaction_timer_if.sv
// Signal bundle between the input stage, the reaction timer and the display logic.
// The timer connects through the slave modport; the producer/consumer side uses master.
interface reaction_timer_if;
  logic        start;
  logic        space_pressed;
  logic        leftClick_pressed;
  logic        stimulus;
  logic        busy;
  logic [13:0] result_ms;
  logic        result_valid;
  logic        too_early;
  logic        timeout;
  logic [13:0] best_ms;

  modport slave (
    input  start, space_pressed, leftClick_pressed,
    output stimulus, busy, result_ms, result_valid, too_early, timeout, best_ms
  );

  modport master (
    output start, space_pressed, leftClick_pressed,
    input  stimulus, busy, result_ms, result_valid, too_early, timeout, best_ms
  );
endinterface

// File: rtl/reaction_timer.sv
// One reaction-time trial per start rise: a pseudo-random wait, then a visual stimulus,
// then the response time in milliseconds, with false-start, timeout and best-score tracking.
module reaction_timer #(
  parameter int          TICKS_PER_MS = 50000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [10:0] DELAY_MASK   = 11'h7FF,
  parameter int          MAX_MS       = 9999
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  reaction_timer_if.slave bus
);

  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);
  localparam logic [13:0]   MAX_C     = 14'(MAX_MS);
  localparam logic [13:0]   MIN_C     = 14'(MIN_DELAY_MS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_GO      = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_EARLY   = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  logic [2:0]    r_state;
  logic [15:0]   r_lfsr;
  logic [TW-1:0] r_tick;
  logic [13:0]   r_msCnt;
  logic [13:0]   r_delayMs;
  logic          r_start, r_startD, r_resp, r_respD;
  logic [13:0]   r_resultMs;
  logic          r_resultValid, r_tooEarly, r_timeout;
  logic [13:0]   r_bestMs;

  logic          w_startRise, w_respRise, w_tickWrap;
  logic          w_delayHit, w_maxHit, w_feedback;
  logic [13:0]   w_msInc, w_hitResult;
  logic [2:0]    w_nextState;

  assign w_startRise = r_start & ~r_startD;
  assign w_respRise  = r_resp & ~r_respD;
  assign w_tickWrap  = (r_tick == TICK_LAST);
  assign w_msInc     = (r_msCnt == MAX_C) ? r_msCnt : r_msCnt + 14'd1;
  assign w_feedback  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Both thresholds look one cycle ahead so the state changes exactly as ms_cnt reaches them.
  assign w_delayHit  = w_tickWrap && (r_msCnt + 14'd1 == r_delayMs);
  assign w_maxHit    = w_tickWrap && (r_msCnt + 14'd1 == MAX_C);
  assign w_hitResult = w_maxHit ? MAX_C : r_msCnt;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_EARLY, S_TIMEOUT:
        if (w_startRise) w_nextState = S_WAIT;
      S_WAIT:
        if (w_respRise)      w_nextState = S_EARLY;
        else if (w_delayHit) w_nextState = S_GO;
      S_GO:
        if (w_respRise)      w_nextState = S_DONE;
        else if (w_maxHit)   w_nextState = S_TIMEOUT;
      default:
        w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_lfsr        <= 16'hACE1;
      r_tick        <= '0;
      r_msCnt       <= '0;
      r_delayMs     <= '0;
      r_start       <= 1'b0;
      r_startD      <= 1'b0;
      r_resp        <= 1'b0;
      r_respD       <= 1'b0;
      r_resultMs    <= '0;
      r_resultValid <= 1'b0;
      r_tooEarly    <= 1'b0;
      r_timeout     <= 1'b0;
      r_bestMs      <= MAX_C;
    end else begin
      r_start       <= bus.start;
      r_startD      <= r_start;
      r_resp        <= bus.space_pressed | bus.leftClick_pressed;
      r_respD       <= r_resp;
      r_lfsr        <= {r_lfsr[14:0], w_feedback};
      r_state       <= w_nextState;
      r_resultValid <= 1'b0;

      if (w_nextState != r_state) begin
        r_tick  <= '0;
        r_msCnt <= '0;
      end else if (w_tickWrap) begin
        r_tick  <= '0;
        r_msCnt <= w_msInc;
      end else begin
        r_tick  <= r_tick + TW'(1);
      end

      case (r_state)
        S_IDLE, S_DONE, S_EARLY, S_TIMEOUT:
          if (w_startRise) begin
            r_delayMs  <= MIN_C + 14'(r_lfsr[10:0] & DELAY_MASK);
            r_tooEarly <= 1'b0;
            r_timeout  <= 1'b0;
          end
        S_WAIT:
          if (w_respRise) r_tooEarly <= 1'b1;
        S_GO:
          if (w_respRise) begin
            r_resultMs    <= w_hitResult;
            r_resultValid <= 1'b1;
            if (w_hitResult < r_bestMs) r_bestMs <= w_hitResult;
          end else if (w_maxHit) begin
            r_resultMs <= MAX_C;
            r_timeout  <= 1'b1;
          end
        default: ;
      endcase
    end
  end

  assign bus.stimulus     = (r_state == S_GO);
  assign bus.busy         = (r_state == S_WAIT) || (r_state == S_GO);
  assign bus.result_ms    = r_resultMs;
  assign bus.result_valid = r_resultValid;
  assign bus.too_early    = r_tooEarly;
  assign bus.timeout      = r_timeout;
  assign bus.best_ms      = r_bestMs;

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: trials are driven with random reaction times and
// outcomes, expected results are queued at stimulus time and checked as each trial ends.
module tb_reaction_timer;

  localparam int          T    = 4;
  localparam int          MIN  = 3;
  localparam logic [10:0] MASK = 11'h00F;
  localparam int          MAX  = 20;

  typedef struct {
    int resultMs;
    bit valid;
    bit early;
    bit tmo;
    int best;
  } expT;

  logic clock;
  logic reset;
  reaction_timer_if bus();

  reaction_timer #(
    .TICKS_PER_MS(T), .MIN_DELAY_MS(MIN), .DELAY_MASK(MASK), .MAX_MS(MAX)
  ) dut (
    .CLOCK_50(clock),
    .reset(reset),
    .bus(bus)
  );

  int          vectors = 0;
  int          miscompares = 0;
  expT         expQ[$];
  int          bestModel = MAX;
  int          lastResult = 0;
  int          cycleCount = 0;
  logic [15:0] lfsrModel = 16'h0000;
  logic [15:0] lfsrPrev = 16'h0000;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference sequence generator; lfsrPrev is the value in force before the latest edge.
  always @(posedge clock) begin
    cycleCount <= cycleCount + 1;
    lfsrPrev   <= lfsrModel;
    if (reset) lfsrModel <= 16'hACE1;
    else lfsrModel <= {lfsrModel[14:0], lfsrModel[15] ^ lfsrModel[13] ^ lfsrModel[12] ^ lfsrModel[10]};
  end

  function automatic int calcDelay(input logic [15:0] seed);
    logic [10:0] low;
    low = seed[10:0] & MASK;
    return MIN + int'(low);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic setResp(input bit useClick, input logic v);
    if (useClick) bus.leftClick_pressed = v;
    else bus.space_pressed = v;
  endtask

  // kind 0: react k cycles after seeing the stimulus, 1: respond during the wait, 2: no response
  task automatic applyStimulus(input int kind, input int k, input bit useClick, input bit startInWait,
                               input bit startInGo, input bit heldSpace, input bit pressWithStart);
    int  n;
    int  d;
    int  kk;
    int  res;
    expT e;
    @(negedge clock);
    bus.start = 1'b1;
    if (pressWithStart) setResp(useClick, 1'b1);
    @(negedge clock);
    bus.start = 1'b0;
    if (pressWithStart) setResp(useClick, 1'b0);
    n = 0;
    while (!bus.busy && n < 10) begin
      @(negedge clock);
      n++;
    end
    checkOutput("busyRise", bus.busy, 1);
    d = calcDelay(lfsrPrev);
    if (kind == 1) begin
      kk = (k > d*T - 2) ? d*T - 2 : k;
      repeat (kk) @(negedge clock);
      setResp(useClick, 1'b1);
      e.resultMs = lastResult; e.valid = 0; e.early = 1; e.tmo = 0; e.best = bestModel;
      expQ.push_back(e);
      @(negedge clock);
      setResp(useClick, 1'b0);
    end else begin
      n = 0;
      while (!bus.stimulus && n < (MIN + 17) * T) begin
        @(negedge clock);
        n++;
        bus.start = startInWait && (n == 2);
      end
      bus.start = 1'b0;
      checkOutput("stimRise", bus.stimulus, 1);
      if (kind == 0) begin
        kk = (k > MAX*T - 2) ? MAX*T - 2 : k;
        for (int i = 0; i < kk; i++) begin
          @(negedge clock);
          bus.start = startInGo && (i == 0);
          if (heldSpace && i == kk - 2) bus.space_pressed = 1'b0;
        end
        bus.start = 1'b0;
        setResp(useClick, 1'b1);
        res = (kk + 1 == MAX*T - 1) ? MAX : (kk + 1) / T;
        lastResult = res;
        if (res < bestModel) bestModel = res;
        e.resultMs = res; e.valid = 1; e.early = 0; e.tmo = 0; e.best = bestModel;
        expQ.push_back(e);
        @(negedge clock);
        setResp(useClick, 1'b0);
      end else begin
        lastResult = MAX;
        e.resultMs = MAX; e.valid = 0; e.early = 0; e.tmo = 1; e.best = bestModel;
        expQ.push_back(e);
      end
    end
    n = 0;
    while (bus.busy && n < MAX*T + 10) begin
      @(negedge clock);
      n++;
    end
    checkOutput("busyFall", bus.busy, 0);
    repeat ($urandom_range(1, 4)) @(negedge clock);
  endtask

  // Monitor: timing of stimulus/timeout, and trial results popped from the scoreboard.
  initial begin
    logic prevBusy, prevStim, checkAfterEnd;
    int   busyRiseCycle, stimCycle, expDelay, strayValid;
    expT  e;
    prevBusy = 0; prevStim = 0; checkAfterEnd = 0;
    busyRiseCycle = 0; stimCycle = 0; expDelay = 0; strayValid = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prevBusy = 0; prevStim = 0; checkAfterEnd = 0; strayValid = 0;
      end else begin
        if (checkAfterEnd) begin
          checkOutput("validWidth", bus.result_valid, 0);
          checkAfterEnd = 0;
        end
        if (!prevBusy && bus.busy) begin
          busyRiseCycle = cycleCount;
          expDelay = calcDelay(lfsrPrev);
        end
        if (!prevStim && bus.stimulus) begin
          stimCycle = cycleCount;
          checkOutput("stimDelay", cycleCount - busyRiseCycle, expDelay * T);
        end
        if (prevBusy && !bus.busy) begin
          if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL trialEnd: got unexpected trial end, expected none pending");
          end else begin
            e = expQ.pop_front();
            checkOutput("resultMs", bus.result_ms, e.resultMs);
            checkOutput("resultValid", bus.result_valid, e.valid);
            checkOutput("tooEarly", bus.too_early, e.early);
            checkOutput("timeout", bus.timeout, e.tmo);
            checkOutput("bestMs", bus.best_ms, e.best);
            checkOutput("stimEnd", bus.stimulus, 0);
            checkOutput("strayValid", strayValid, 0);
            if (e.tmo) checkOutput("timeoutDelay", cycleCount - stimCycle, MAX * T);
          end
          checkAfterEnd = 1;
          strayValid = 0;
        end else if (bus.result_valid) begin
          strayValid++;
        end
        prevBusy = bus.busy;
        prevStim = bus.stimulus;
      end
    end
  end

  initial begin
    int n;
    int kind;
    int k;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.space_pressed = 1'b0;
    bus.leftClick_pressed = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstStim", bus.stimulus, 0);
    checkOutput("rstResult", bus.result_ms, 0);
    checkOutput("rstValid", bus.result_valid, 0);
    checkOutput("rstEarly", bus.too_early, 0);
    checkOutput("rstTimeout", bus.timeout, 0);
    checkOutput("rstBest", bus.best_ms, MAX);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    applyStimulus(0, 7*T, 0, 0, 0, 0, 0);
    applyStimulus(0, 4*T, 1, 0, 0, 0, 0);
    applyStimulus(0, 9*T, 0, 0, 0, 0, 0);
    applyStimulus(1, 5, 1, 0, 0, 0, 0);
    applyStimulus(2, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 9, 0, 0, 0, 0, 0);
    applyStimulus(0, 10, 0, 1, 1, 0, 0);
    applyStimulus(1, 1000, 0, 0, 0, 0, 0);
    applyStimulus(0, MAX*T - 2, 1, 0, 0, 0, 0);
    applyStimulus(0, 6, 0, 0, 0, 0, 1);

    for (int t = 0; t < 25; t++) begin
      kind = $urandom_range(0, 2);
      k = (kind == 0) ? $urandom_range(0, MAX*T - 2) : $urandom_range(0, 60);
      applyStimulus(kind, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    (k >= 2) && ($urandom_range(0, 1) == 1), 1'b0, 1'($urandom_range(0, 1)));
    end

    // Abort a trial in GO with reset, holding space through and past the reset.
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    while (!bus.stimulus && n < (MIN + 20) * T) begin
      @(negedge clock);
      n++;
    end
    checkOutput("abortStim", bus.stimulus, 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    bus.space_pressed = 1'b1;
    @(negedge clock);
    checkOutput("abortBusy", bus.busy, 0);
    checkOutput("abortStimOff", bus.stimulus, 0);
    checkOutput("abortBest", bus.best_ms, MAX);
    checkOutput("abortValid", bus.result_valid, 0);
    bestModel = MAX;
    lastResult = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    applyStimulus(0, 6, 0, 0, 0, 1, 0);

    repeat (4) @(negedge clock);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
